// File: rtl/meas_pkg.sv
// Shared definitions for the phase-counting measurement controllers.
package meas_pkg;

  localparam int CNT_WIDTH = 32;
  localparam int PHASES    = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    WAIT_VALID,
    LOCK,
    CAPTURE,
    RESULT
  } duty_ctrl_state_t;

endpackage

// File: rtl/meas_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module meas_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/duty_meas_ctrl.sv
// Duty measurement sequencer: clears and gates the phase counter, locks it,
// captures the clamped high count and offers it to the host.
module duty_meas_ctrl #(
  parameter int CNT_WIDTH      = meas_pkg::CNT_WIDTH,
  parameter int GATE_CYCLES    = 1000,
  parameter int CLR_CYCLES     = 4,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 meas_rst,
  output logic                 gate,
  input  logic                 cnt_valid,
  output logic                 cnt_lock,
  input  logic [CNT_WIDTH-1:0] duty_cnt,
  output logic [CNT_WIDTH-1:0] high_cnt,
  output logic [CNT_WIDTH-1:0] period_cnt,
  output logic                 result_valid,
  input  logic                 result_ready,
  output logic                 timeout_err,
  output logic                 range_err
);

  import meas_pkg::*;

  localparam logic [CNT_WIDTH-1:0] PERIOD =
    CNT_WIDTH'(longint'(PHASES) * longint'(GATE_CYCLES));

  // Timer is loaded with N-1 so each timed state lasts exactly N cycles.
  localparam logic [CNT_WIDTH-1:0] CLR_LOAD     = CNT_WIDTH'(CLR_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GATE_LOAD    = CNT_WIDTH'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  duty_ctrl_state_t state, next_state;
  logic                 timer_load;
  logic [CNT_WIDTH-1:0] timer_val;
  logic                 timer_done;
  logic                 over_range;

  assign period_cnt = PERIOD;
  assign over_range = (duty_cnt > PERIOD);

  meas_timer #(.WIDTH(CNT_WIDTH)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    timer_val  = '0;
    case (state)
      IDLE:       if (start) next_state = CLEAR;
      CLEAR:      if (timer_done) next_state = GATE;
      GATE:       if (timer_done) next_state = SETTLE;
      SETTLE:     if (timer_done) next_state = WAIT_VALID;
      WAIT_VALID: begin
        if (cnt_valid) begin
          next_state = LOCK;
        end else if (timer_done) begin
          next_state = RESULT;
        end
      end
      LOCK:       next_state = CAPTURE;
      CAPTURE:    next_state = RESULT;
      RESULT:     if (result_ready) next_state = IDLE;
      default:    next_state = IDLE;
    endcase
    timer_load = (next_state != state);
    case (next_state)
      CLEAR:      timer_val = CLR_LOAD;
      GATE:       timer_val = GATE_LOAD;
      SETTLE:     timer_val = SETTLE_LOAD;
      WAIT_VALID: timer_val = TIMEOUT_LOAD;
      default:    timer_val = '0;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy         <= 1'b0;
      meas_rst     <= 1'b0;
      gate         <= 1'b0;
      cnt_lock     <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      range_err    <= 1'b0;
      high_cnt     <= '0;
    end else begin
      busy         <= (next_state != IDLE);
      meas_rst     <= (next_state == CLEAR);
      gate         <= (next_state == GATE);
      cnt_lock     <= (next_state == LOCK) || (next_state == CAPTURE);
      result_valid <= (next_state == RESULT);
      if (state == IDLE && start) begin
        timeout_err <= 1'b0;
        range_err   <= 1'b0;
      end
      if (state == WAIT_VALID && !cnt_valid && timer_done) begin
        timeout_err <= 1'b1;
        high_cnt    <= '0;
      end
      if (state == CAPTURE) begin
        high_cnt  <= over_range ? PERIOD : duty_cnt;
        range_err <= over_range;
      end
    end
  end

endmodule

// File: tb/tb_duty_meas_ctrl.sv
// Scenario bench for duty_meas_ctrl with a queue of expected results.
module tb_duty_meas_ctrl;

  localparam int W  = 32;
  localparam int GC = 100;
  localparam int CC = 4;
  localparam int SC = 8;
  localparam int TC = 16;
  localparam logic [W-1:0] PERIOD = 32'd400;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         busy, meas_rst, gate, cnt_lock;
  logic         cnt_valid = 1'b0;
  logic [W-1:0] duty_cnt = '0;
  logic [W-1:0] high_cnt, period_cnt;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic         timeout_err, range_err;

  typedef struct packed {
    logic [W-1:0] high;
    logic         terr;
    logic         rerr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_no = 0;
  int   mr_first, mr_n, g_first, g_n, lk_first, lk_n, rv_edge;

  duty_meas_ctrl #(
    .CNT_WIDTH(W), .GATE_CYCLES(GC), .CLR_CYCLES(CC),
    .SETTLE_CYCLES(SC), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .meas_rst(meas_rst),
    .gate(gate), .cnt_valid(cnt_valid), .cnt_lock(cnt_lock),
    .duty_cnt(duty_cnt), .high_cnt(high_cnt), .period_cnt(period_cnt),
    .result_valid(result_valid), .result_ready(result_ready),
    .timeout_err(timeout_err), .range_err(range_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
  endtask

  // Edge numbering: the edge that samples start is edge 1.
  task automatic issue_start();
    start = 1'b1;
    edge_no = 0;
    step();
    start = 1'b0;
  endtask

  task automatic trace_to_result(input int bound, input int valid_at, input int drop_at);
    mr_first = -1; mr_n = 0; g_first = -1; g_n = 0;
    lk_first = -1; lk_n = 0; rv_edge = -1;
    while (edge_no <= bound && rv_edge < 0) begin
      if (meas_rst) begin if (mr_first < 0) mr_first = edge_no; mr_n++; end
      if (gate)     begin if (g_first < 0)  g_first  = edge_no; g_n++;  end
      if (cnt_lock) begin if (lk_first < 0) lk_first = edge_no; lk_n++; end
      if (result_valid) begin
        rv_edge = edge_no;
      end else begin
        if (edge_no == valid_at) cnt_valid = 1'b1;
        if (edge_no == drop_at)  cnt_valid = 1'b0;
        step();
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) step();
    vectors++;
    if ({busy, meas_rst, gate, cnt_lock, result_valid} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {busy, meas_rst, gate, cnt_lock, result_valid});
    end
    vectors++;
    if ({timeout_err, range_err} !== 2'b0 || high_cnt !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_result: got err=%b high=%0d expected 00 / 0", {timeout_err, range_err}, high_cnt);
    end
    vectors++;
    if (period_cnt !== PERIOD) begin
      miscompares++;
      $display("[TB] FAIL period_cnt: got %0d expected %0d", period_cnt, PERIOD);
    end
    rst = 1'b0; start = 1'b0;
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_normal();
    exp_t e;
    cnt_valid = 1'b1; duty_cnt = 200; result_ready = 1'b1;
    exp_q.push_back('{high: 32'd200, terr: 1'b0, rerr: 1'b0});
    issue_start();
    vectors++;
    if (busy !== 1'b1 || meas_rst !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_edge: got busy=%b meas_rst=%b expected 1 1", busy, meas_rst);
    end
    trace_to_result(300, -1, -1);
    vectors++;
    if (mr_first !== 1 || mr_n !== CC) begin
      miscompares++;
      $display("[TB] FAIL meas_rst_window: got first=%0d len=%0d expected 1 %0d", mr_first, mr_n, CC);
    end
    vectors++;
    if (g_first !== 5 || g_n !== GC) begin
      miscompares++;
      $display("[TB] FAIL gate_window: got first=%0d len=%0d expected 5 %0d", g_first, g_n, GC);
    end
    vectors++;
    if (lk_first !== 114 || lk_n !== 2) begin
      miscompares++;
      $display("[TB] FAIL lock_window: got first=%0d len=%0d expected 114 2", lk_first, lk_n);
    end
    vectors++;
    if (rv_edge !== 116) begin
      miscompares++;
      $display("[TB] FAIL normal_rv_edge: got %0d expected 116", rv_edge);
    end
    e = exp_q.pop_front();
    vectors++;
    if (high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL normal_result: got %0d/%b/%b expected %0d/%b/%b", high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
    end
    step();
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL valid_one_cycle: got valid=%b busy=%b expected 0 0", result_valid, busy);
    end
  endtask

  // Consecutive measurements around the clamp boundary, ready held high.
  task automatic test_back_to_back();
    logic [W-1:0] duties [4];
    exp_t e;
    duties[0] = 500; duties[1] = 400; duties[2] = 401; duties[3] = 0;
    cnt_valid = 1'b1; result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      duty_cnt = duties[i];
      exp_q.push_back('{high: (duties[i] > PERIOD) ? PERIOD : duties[i],
                        terr: 1'b0, rerr: (duties[i] > PERIOD)});
      issue_start();
      trace_to_result(300, -1, -1);
      e = exp_q.pop_front();
      vectors++;
      if (rv_edge !== 116 || high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
        miscompares++;
        $display("[TB] FAIL range_%0d: got edge=%0d %0d/%b/%b expected edge=116 %0d/%b/%b",
                 i, rv_edge, high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
      end
      step();
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    cnt_valid = 1'b0; duty_cnt = 123; result_ready = 1'b1;
    exp_q.push_back('{high: 32'd0, terr: 1'b1, rerr: 1'b0});
    issue_start();
    trace_to_result(300, -1, -1);
    vectors++;
    if (rv_edge !== 129 || lk_n !== 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_timing: got edge=%0d locks=%0d expected 129 0", rv_edge, lk_n);
    end
    e = exp_q.pop_front();
    vectors++;
    if (high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL timeout_result: got %0d/%b/%b expected %0d/%b/%b", high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
    end
    step();
  endtask

  task automatic test_backpressure();
    exp_t e;
    int unstable = 0;
    cnt_valid = 1'b1; duty_cnt = 600; result_ready = 1'b0;
    exp_q.push_back('{high: PERIOD, terr: 1'b0, rerr: 1'b1});
    issue_start();
    trace_to_result(300, -1, -1);
    e = exp_q.pop_front();
    vectors++;
    if (rv_edge !== 116 || high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL bp_result: got edge=%0d %0d/%b/%b expected edge=116 %0d/%b/%b",
               rv_edge, high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
    end
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      step();
      if (result_valid !== 1'b1 || busy !== 1'b1 || high_cnt !== e.high ||
          range_err !== e.rerr || timeout_err !== e.terr) unstable++;
    end
    start = 1'b0;
    vectors++;
    if (unstable !== 0) begin
      miscompares++;
      $display("[TB] FAIL bp_hold: got %0d unstable cycles expected 0", unstable);
    end
    start = 1'b1; result_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL start_with_ready: got valid=%b busy=%b expected 0 0", result_valid, busy);
    end
    duty_cnt = 250;
    exp_q.push_back('{high: 32'd250, terr: 1'b0, rerr: 1'b0});
    issue_start();
    vectors++;
    if (range_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL flags_cleared_on_start: got range_err=%b expected 0", range_err);
    end
    trace_to_result(300, -1, -1);
    e = exp_q.pop_front();
    vectors++;
    if (rv_edge !== 116 || high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL fresh_result: got edge=%0d %0d/%b/%b expected edge=116 %0d/%b/%b",
               rv_edge, high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
    end
    step();
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int stray = 0;
    cnt_valid = 1'b1; duty_cnt = 321; result_ready = 1'b1;
    issue_start();
    while (edge_no < 50) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if ({gate, meas_rst, cnt_lock, busy} !== 4'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid: got gate/rst/lock/busy=%b expected 0000", {gate, meas_rst, cnt_lock, busy});
    end
    repeat (130) begin
      step();
      if (result_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray !== 0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_idle: got %0d active cycles expected 0", stray);
    end
    exp_q.push_back('{high: 32'd321, terr: 1'b0, rerr: 1'b0});
    issue_start();
    trace_to_result(300, -1, -1);
    e = exp_q.pop_front();
    vectors++;
    if (g_first !== 5 || g_n !== GC || rv_edge !== 116 || high_cnt !== e.high ||
        timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL after_reset_run: got gate=%0d/%0d edge=%0d %0d/%b/%b expected 5/%0d 116 %0d/%b/%b",
               g_first, g_n, rv_edge, high_cnt, timeout_err, range_err, GC, e.high, e.terr, e.rerr);
    end
    step();
  endtask

  // Valid arrives as the timeout expires, then drops during LOCK.
  task automatic test_late_valid();
    exp_t e;
    cnt_valid = 1'b0; duty_cnt = 77; result_ready = 1'b1;
    exp_q.push_back('{high: 32'd77, terr: 1'b0, rerr: 1'b0});
    issue_start();
    trace_to_result(300, 128, 129);
    vectors++;
    if (lk_first !== 129 || lk_n !== 2 || rv_edge !== 131) begin
      miscompares++;
      $display("[TB] FAIL late_valid_timing: got lock=%0d/%0d rv=%0d expected 129/2 131", lk_first, lk_n, rv_edge);
    end
    e = exp_q.pop_front();
    vectors++;
    if (high_cnt !== e.high || timeout_err !== e.terr || range_err !== e.rerr) begin
      miscompares++;
      $display("[TB] FAIL late_valid_result: got %0d/%b/%b expected %0d/%b/%b", high_cnt, timeout_err, range_err, e.high, e.terr, e.rerr);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_late_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/duty_meas_ctrl.md
# duty_meas_ctrl

Sequencer and reader for the phase-counting duty measurement counter. It starts a measurement window by clearing the counter and opening the gate. After the gate closes, it waits for the counter's `cnt_valid`, freezes the counter with `cnt_lock`, and captures `duty_cnt`. It then presents the high count, the full-scale count and error flags to the host through a valid/ready handshake.

## Interface
Parameters:
- `CNT_WIDTH`, default 32: width of the counter and result.
- `GATE_CYCLES`, default 1000: gate length in `clk` cycles; range 1 to 2^(CNT_WIDTH-2)-1.
- `CLR_CYCLES`, default 4: `meas_rst` pulse length; must be ≥1.
- `SETTLE_CYCLES`, default 8: gap between gate fall and the start of the wait for valid; must be ≥1.
- `TIMEOUT_CYCLES`, default 256: maximum wait for `cnt_valid`; must be ≥1.

Ports:
- `clk` in 1: single clock, the 0° phase clock of the counter.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a measurement; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `meas_rst` out 1: clear pulse to the counter.
- `gate` out 1: measurement window to the counter.
- `cnt_valid` in 1: counter result ready.
- `cnt_lock` out 1: freeze request to the counter.
- `duty_cnt` in CNT_WIDTH: counter sum of the four phase counts.
- `high_cnt` out CNT_WIDTH: captured, clamped high count.
- `period_cnt` out CNT_WIDTH: full-scale count, constant 4·GATE_CYCLES.
- `result_valid` out 1: result available.
- `result_ready` in 1: host accepts the result.
- `timeout_err` out 1: `cnt_valid` never arrived.
- `range_err` out 1: `duty_cnt` exceeded `period_cnt`.

## Operation
- States are IDLE, CLEAR, GATE, SETTLE, WAIT_VALID, LOCK, CAPTURE and RESULT. State encoding is one-hot or binary; the choice is free.
- **IDLE:** if `start`=1, go to CLEAR. Clear both error flags at this point.
- **CLEAR:** `meas_rst`=1 for exactly CLR_CYCLES cycles, then go to GATE.
- **GATE:** `gate`=1 for exactly GATE_CYCLES cycles, then go to SETTLE.
- **SETTLE:** `gate`=0 for SETTLE_CYCLES cycles, then go to WAIT_VALID.
- **WAIT_VALID:**
  - If `cnt_valid`=1, go to LOCK.
  - Otherwise count cycles. After TIMEOUT_CYCLES cycles without valid, set `timeout_err`, load `high_cnt`=0 and go to RESULT.
- **LOCK:** `cnt_lock`=1 for one cycle, then go to CAPTURE.
- **CAPTURE:** `cnt_lock` stays 1.
  - Register `high_cnt` = min(`duty_cnt`, `period_cnt`).
  - Set `range_err` if `duty_cnt` > `period_cnt`.
  - Go to RESULT.
- **RESULT:** `cnt_lock`=0 and `result_valid`=1.
  - `high_cnt` and both error flags are held stable until `result_ready`=1.
  - When `result_ready`=1, go to IDLE and drop `result_valid` on the next cycle.
- A single shared down-counter of width CNT_WIDTH is reloaded on every state entry and serves CLEAR, GATE, SETTLE and WAIT_VALID.
- `period_cnt` is computed at elaboration time. Comparison is unsigned at CNT_WIDTH bits.

## Timing
- All outputs are registered.
- Reset values:
  - `busy`, `meas_rst`, `gate`, `cnt_lock`, `result_valid`, `timeout_err`, `range_err` = 0.
  - `high_cnt` = 0.
  - `period_cnt` = 4·GATE_CYCLES, constant.
  - State = IDLE.
- `start` high in cycle t is sampled in IDLE:
  - `busy` and `meas_rst` go high at edge t+1.
  - `gate` rises at edge t+1+CLR_CYCLES and is high for exactly GATE_CYCLES cycles.
- If `cnt_valid` is already high on entry to WAIT_VALID:
  - `cnt_lock` rises 1 cycle later.
  - `result_valid` rises 3 cycles after entry to WAIT_VALID.
- Boundary cases:
  - `start` while `busy` is ignored.
  - `start` and `result_ready` high in the same RESULT cycle: return to IDLE; `start` is not honoured in that cycle.
  - `cnt_valid` and the timeout expiring in the same cycle: valid wins, no error.
  - `cnt_valid` dropping during LOCK or CAPTURE has no effect.
  - `rst` mid-measurement: on the next edge `gate`, `meas_rst` and `cnt_lock` go low and the state returns to IDLE. No partial result is presented.
  - `result_ready` held high continuously: each result is valid for exactly 1 cycle.

## Structure
- The shared package `meas_pkg` holds `CNT_WIDTH`, the state enum `duty_ctrl_state_t` and the `PHASES`=4 constant. The measure_fre controller reuses them.
- One natural sub-module, `meas_timer`: a loadable down-counter with a `done` flag, used for CLEAR, GATE, SETTLE and timeout timing.

## Test plan
All scenarios use GATE_CYCLES=100, CLR=4, SETTLE=8, TIMEOUT=16, so `period_cnt`=400.
- **Normal measurement:** `start` at cycle 0 → `meas_rst` high cycles 1–4, `gate` high cycles 5–104. With `cnt_valid` tied high and `duty_cnt`=200: `result_valid` with `high_cnt`=200, both error flags 0.
- **Range error:** `duty_cnt`=0x1F4 (500) → `high_cnt`=400, `range_err`=1.
- **Timeout:** `cnt_valid` held 0 → `timeout_err`=1 and `high_cnt`=0 exactly 16 cycles after WAIT_VALID entry; `cnt_lock` never asserted.
- **Backpressure:** `result_ready` low for 10 cycles → result held stable; `start` pulses during `busy` are ignored; the next `start` after the handshake runs a fresh measurement with both error flags cleared.
- **Reset mid-gate:** `rst` at cycle 50 → `gate` low at cycle 51, `busy`=0, no `result_valid`; a new `start` then behaves as in scenario 1.
- **Late valid:** `cnt_valid` rises 15 cycles after WAIT_VALID entry, in the same cycle the timeout expires → result taken from `duty_cnt`, `timeout_err`=0.
